// File: rtl/tug_key_conditioner.sv
// Tug-of-war key input stage: sync, debounce and one-shot press pulses per player.
// Optional AUTO_REPEAT_EN adds periodic repeat pulses while a key stays held.
module tug_key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 16,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic key_l,
  input  logic key_r,
  output logic L,
  output logic R
);

  localparam int   CW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic REL = (ACTIVE_LOW != 0);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_chk
    $error("DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    REL_WAIT
  } state_t;

  logic [1:0] w_raw;
  logic [1:0] w_pulse;

  assign w_raw = {key_r, key_l};
  assign L     = w_pulse[0];
  assign R     = w_pulse[1];

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic          r_s1;
    logic          r_s2;
    logic          w_pressed;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_pulse;
    logic          w_pulse_nxt;
    logic          w_rep;

    assign w_pressed  = r_s2 ^ REL;
    assign w_pulse[g] = r_pulse;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_s1    <= REL;
        r_s2    <= REL;
        r_state <= IDLE;
        r_cnt   <= '0;
        r_pulse <= 1'b0;
      end else begin
        r_s1    <= w_raw[g];
        r_s2    <= r_s1;
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_pulse <= w_pulse_nxt;
      end
    end

`ifdef AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    logic [RW-1:0] r_rcnt;
    logic [RW-1:0] w_rcnt_nxt;

    always_ff @(posedge clk) begin
      if (reset) r_rcnt <= '0;
      else       r_rcnt <= w_rcnt_nxt;
    end

    // Repeat timer runs only while HELD; any HELD entry restarts it.
    always_comb begin
      w_rep      = 1'b0;
      w_rcnt_nxt = r_rcnt;
      if (w_state_nxt == HELD && r_state != HELD) begin
        w_rcnt_nxt = '0;
      end else if (r_state == HELD && w_pressed) begin
        if (r_rcnt == RW'(REPEAT_CYCLES - 1)) begin
          w_rep      = 1'b1;
          w_rcnt_nxt = '0;
        end else begin
          w_rcnt_nxt = r_rcnt + 1'b1;
        end
      end
    end
`else
    assign w_rep = 1'b0;
`endif

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_pulse_nxt = w_rep;
      unique case (r_state)
        IDLE: begin
          if (w_pressed) begin
            w_state_nxt = PRESS_WAIT;
            w_cnt_nxt   = CW'(1);
          end
        end
        PRESS_WAIT: begin
          if (!w_pressed) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == CW'(DEBOUNCE_CYCLES)) begin
            w_state_nxt = HELD;
            w_cnt_nxt   = '0;
            w_pulse_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        HELD: begin
          if (!w_pressed) begin
            w_state_nxt = REL_WAIT;
            w_cnt_nxt   = CW'(1);
          end
        end
        REL_WAIT: begin
          if (w_pressed) begin
            w_state_nxt = HELD;
            w_cnt_nxt   = '0;
          end else if (r_cnt == CW'(DEBOUNCE_CYCLES)) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tug_key_conditioner.sv
// Directed bench for tug_key_conditioner (default parameters, active-low keys).
// Edge numbering: a key change applied before edge 1 yields its pulse after edge 7.
module tb_tug_key_conditioner;

  logic clk;
  logic reset;
  logic key_l;
  logic key_r;
  logic L;
  logic R;

  int checks = 0;
  int fails  = 0;

  tug_key_conditioner dut (
    .clk  (clk),
    .reset(reset),
    .key_l(key_l),
    .key_r(key_r),
    .L    (L),
    .R    (R)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_idle(input int n);
    key_l = 1'b1;
    key_r = 1'b1;
    for (int e = 1; e <= n; e++) begin
      tick();
      checks++;
      if (L !== 1'b0 || R !== 1'b0) begin
        fails++;
        $display("FAIL release_idle e%0d: L=%b R=%b want 0 0", e, L, R);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    key_l = 1'b1;
    key_r = 1'b1;
    tick();
    tick();
    checks++;
    if (L !== 1'b0 || R !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: L=%b R=%b want 0 0", L, R);
    end
    reset = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      checks++;
      if (L !== 1'b0 || R !== 1'b0) begin
        fails++;
        $display("FAIL post_reset_idle e%0d: L=%b R=%b want 0 0", e, L, R);
      end
    end
  endtask

  task automatic test_single_press();
    key_l = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      checks++;
      if (L !== (e == 7) || R !== 1'b0) begin
        fails++;
        $display("FAIL single_press e%0d: L=%b R=%b want %b 0", e, L, R, e == 7);
      end
    end
    release_idle(10);
  endtask

  task automatic test_bounce();
    for (int e = 1; e <= 16; e++) begin
      key_r = (e == 2 || e == 4);
      tick();
      checks++;
      if (R !== (e == 11) || L !== 1'b0) begin
        fails++;
        $display("FAIL bounce e%0d: R=%b L=%b want %b 0", e, R, L, e == 11);
      end
    end
    release_idle(10);
  endtask

  task automatic test_release_glitch();
    for (int e = 1; e <= 20; e++) begin
      key_l = (e == 11 || e == 12);
      tick();
      checks++;
      if (L !== (e == 7)) begin
        fails++;
        $display("FAIL release_glitch e%0d: L=%b want %b", e, L, e == 7);
      end
    end
    release_idle(8);
    key_l = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      checks++;
      if (L !== (e == 7)) begin
        fails++;
        $display("FAIL second_press e%0d: L=%b want %b", e, L, e == 7);
      end
    end
    release_idle(10);
  endtask

  task automatic test_simultaneous();
    key_l = 1'b0;
    key_r = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      checks++;
      if (L !== (e == 7) || R !== (e == 7)) begin
        fails++;
        $display("FAIL simultaneous e%0d: L=%b R=%b want %b %b", e, L, R, e == 7, e == 7);
      end
    end
    release_idle(10);
  endtask

  task automatic test_reset_abort();
    key_l = 1'b0;
    for (int e = 1; e <= 3; e++) tick();
    reset = 1'b1;
    key_l = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      checks++;
      if (L !== 1'b0 || R !== 1'b0) begin
        fails++;
        $display("FAIL reset_abort e%0d: L=%b R=%b want 0 0", e, L, R);
      end
    end
  endtask

  task automatic test_held_through_reset();
    key_l = 1'b0;
    for (int e = 1; e <= 3; e++) tick();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (L !== 1'b0) begin
      fails++;
      $display("FAIL held_in_reset: L=%b want 0", L);
    end
    reset = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      checks++;
      if (L !== (e == 7)) begin
        fails++;
        $display("FAIL held_through_reset e%0d: L=%b want %b", e, L, e == 7);
      end
    end
    release_idle(10);
  endtask

  task automatic test_repeat_mode();
    logic exp;
    key_l = 1'b0;
    for (int e = 1; e <= 40; e++) begin
`ifdef AUTO_REPEAT_EN
      exp = (e == 7 || e == 23 || e == 39);
`else
      exp = (e == 7);
`endif
      tick();
      checks++;
      if (L !== exp) begin
        fails++;
        $display("FAIL long_hold e%0d: L=%b want %b", e, L, exp);
      end
    end
    release_idle(10);
  endtask

  initial begin
    reset = 1'b1;
    key_l = 1'b1;
    key_r = 1'b1;
    test_reset();
    test_single_press();
    test_bounce();
    test_release_glitch();
    test_simultaneous();
    test_reset_abort();
    test_held_through_reset();
    test_repeat_mode();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
